// File: rtl/picorv32_regs_pkg.sv
// Shared types and constants for the picorv32 register-file controller.
// Build option: PICORV32_REGS_CTRL_DBG_EN enables the debug access port.
package picorv32_regs_pkg;

    localparam int NREGS = 31;
    localparam int AW    = 6;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DBG_RD = 2'd2,
        ST_DBG_WR = 2'd3
    } state_t;

    // x0 is hardwired to zero, and the upper half of the 6-bit space has no backing storage.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (addr[4:0] == 5'd0) || addr[5];
    endfunction

endpackage

// File: rtl/picorv32_regs_ctrl.sv
// Front-end controller for the picorv32 register-file macro: clears x1..x31 after
// reset, gates core accesses (x0 and the upper half of the address space read as
// zero, and writes to them are dropped), and arbitrates a debug port.
// Build option: PICORV32_REGS_CTRL_DBG_EN adds the DBG_RD/DBG_WR states; without it
// the debug inputs are ignored and dbg_ack/dbg_rdata are tied to 0.
//
// state     | meaning
// ST_INIT   | sweep x1..x31 with INIT_VALUE, core held off
// ST_RUN    | core pass-through, debug requests accepted while core halted
// ST_DBG_RD | debug read, macro read port 1 steered to dbg_addr
// ST_DBG_WR | debug write, acked in the same cycle
module picorv32_regs_ctrl
    import picorv32_regs_pkg::*;
#(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_wen,
    input  logic [AW-1:0] cpu_waddr,
    input  logic [31:0]   cpu_wdata,
    input  logic [AW-1:0] cpu_raddr1,
    input  logic [AW-1:0] cpu_raddr2,
    output logic [31:0]   cpu_rdata1,
    output logic [31:0]   cpu_rdata2,
    input  logic          cpu_halted,
    output logic          regs_wen,
    output logic [AW-1:0] regs_waddr,
    output logic [31:0]   regs_wdata,
    output logic [AW-1:0] regs_raddr1,
    output logic [AW-1:0] regs_raddr2,
    input  logic [31:0]   regs_rdata1,
    input  logic [31:0]   regs_rdata2,
    output logic          init_done,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [4:0]    dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata
);

    state_t     state;
    state_t     state_nxt;
    logic [4:0] cnt;

    // State register and sweep counter; cnt wraps to 0 after x31 and idles there.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
            cnt   <= 5'd1;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                cnt <= cnt + 5'd1;
            end
        end
    end

`ifdef PICORV32_REGS_CTRL_DBG_EN
    logic        rd_ack;
    logic [31:0] rd_data;

    // Capture the debug read result one cycle after DBG_RD and pulse the ack with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack  <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            rd_ack <= (state == ST_DBG_RD);
            if (state == ST_DBG_RD) begin
                rd_data <= (dbg_addr == 5'd0) ? 32'd0 : regs_rdata1;
            end
        end
    end

    assign dbg_ack   = !rst && ((state == ST_DBG_WR) || rd_ack);
    assign dbg_rdata = rd_data;
`else
    logic unused_dbg;
    assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata, cpu_halted};
    assign dbg_ack    = 1'b0;
    assign dbg_rdata  = 32'd0;
`endif

    // Next-state and macro port steering; reset suppresses any write in flight.
    always_comb begin
        state_nxt   = state;
        regs_wen    = 1'b0;
        regs_waddr  = cpu_waddr;
        regs_wdata  = cpu_wdata;
        regs_raddr1 = cpu_raddr1;
        regs_raddr2 = cpu_raddr2;
        case (state)
            ST_INIT: begin
                regs_wen   = 1'b1;
                regs_waddr = {1'b0, cnt};
                regs_wdata = INIT_VALUE;
                if (cnt == 5'(NREGS)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                regs_wen = cpu_wen && !is_zero_reg(cpu_waddr);
`ifdef PICORV32_REGS_CTRL_DBG_EN
                // The requester still holds dbg_req during the read ack cycle.
                if (dbg_req && cpu_halted && !rd_ack) begin
                    state_nxt = dbg_we ? ST_DBG_WR : ST_DBG_RD;
                end
`endif
            end
`ifdef PICORV32_REGS_CTRL_DBG_EN
            ST_DBG_WR: begin
                regs_wen   = (dbg_addr != 5'd0);
                regs_waddr = {1'b0, dbg_addr};
                regs_wdata = dbg_wdata;
                state_nxt  = ST_RUN;
            end
            ST_DBG_RD: begin
                regs_raddr1 = {1'b0, dbg_addr};
                state_nxt   = ST_RUN;
            end
`endif
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        if (rst) begin
            regs_wen = 1'b0;
        end
    end

    // Core read data: forced to zero during the sweep and for x0 / out-of-range addresses.
    always_comb begin
        cpu_rdata1 = regs_rdata1;
        cpu_rdata2 = regs_rdata2;
        if (state == ST_INIT || is_zero_reg(cpu_raddr1)) cpu_rdata1 = 32'd0;
        if (state == ST_INIT || is_zero_reg(cpu_raddr2)) cpu_rdata2 = 32'd0;
    end

    assign init_done = (state != ST_INIT);

endmodule
